mips_control_sequencer: RTL and testbench
=========================================

Name: mips_control_sequencer

Overview:
- Multi-cycle control unit that drives the datapath control inputs: DMRST, DMWE, RFRST, RFWE, ALUsel, PCRRST, plus PC/IR/mux selects.
- After its own reset it sequences the datapath resets, then runs a FETCH/DECODE/EXEC/MEM/WB state machine per instruction.
- Sits beside the datapath. Takes opcode/funct/zero from the datapath and returns all control strobes.

Parameters:
- RST_CYCLES, 2, cycles DMRST/RFRST/PCRRST are held high after CURST deasserts (range 1-15).

Ports:
- CLK  in  1  system clock, rising edge
- CURST  in  1  asynchronous, active-high reset of the sequencer
- OPCODE  in  6  instruction[31:26] from the instruction register
- FUNCT  in  6  instruction[5:0]
- ZERO  in  1  ALU zero flag
- DMRST  out  1  data memory reset
- RFRST  out  1  register file reset
- PCRRST  out  1  PC register reset
- IRWE  out  1  instruction register write enable
- PCWE  out  1  PC write enable
- PCSRC  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- RFWE  out  1  register file write enable
- REGDST  out  1  1 = rd, 0 = rt
- ALUSRC  out  1  1 = sign-extended immediate, 0 = rt
- MEMTOREG  out  1  1 = memory data, 0 = ALU result
- DMWE  out  1  data memory write enable
- ALUsel  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- ILLEGAL  out  1  one-cycle pulse on an unsupported opcode/funct

Behaviour:
- CURST high asynchronously forces:
  - state RSTSEQ, counter 0
  - DMRST = RFRST = PCRRST = 1
  - every enable (IRWE, PCWE, RFWE, DMWE) = 0, ILLEGAL = 0
  - PCSRC = 00, ALUsel = 0010, all muxes 0
- RSTSEQ: resets stay high for RST_CYCLES rising edges after CURST falls, then drop together on entry to FETCH.
- Outputs are registered, valid the same cycle as the state they belong to.
- FETCH: IRWE = 1, PCWE = 1, PCSRC = 00, ALUsel = 0010. Next state DECODE.
- DECODE: latch OPCODE/FUNCT internally; no enables. Next state:
  - EXEC for R-type (000000), lw (100011), sw (101011), addi (001000), beq (000100)
  - FETCH for j (000010), with PCWE = 1 and PCSRC = 10 issued this cycle
  - anything else, or R-type with a funct outside {100000, 100010, 100100, 100101, 101010}: ILLEGAL pulse, back to FETCH, no write enables
- EXEC:
  - R-type: REGDST = 1, ALUsel from funct (add 0010, sub 0110, and 0000, or 0001, slt 0111). Next WB.
  - lw/sw/addi: ALUSRC = 1, ALUsel 0010. lw/sw go to MEM; addi goes to WB.
  - beq: ALUsel 0110. PCWE = ZERO, PCSRC = 01 (ZERO sampled this cycle). Next FETCH.
- MEM:
  - sw: DMWE = 1 for exactly one cycle, next FETCH.
  - lw: DMWE = 0, next WB.
- WB: RFWE = 1 for exactly one cycle. MEMTOREG = 1 for lw; REGDST = 1 for R-type; ALUsel/ALUSRC held from EXEC. Next FETCH.
- Instruction latency in cycles (FETCH to next FETCH): R 4, addi 4, lw 5, sw 4, beq 3, j 2, illegal 2.
- Invariants:
  - DMWE and RFWE are never high in the same cycle.
  - No enable is high while any datapath reset is high.
- CURST asserted mid-instruction aborts immediately. No partial DMWE/RFWE pulse survives past the reset edge.
- OPCODE/FUNCT changes outside DECODE are ignored.

Test Plan:
- CURST = 1 for 3 cycles, then 0, RST_CYCLES = 2 -> resets high for 2 edges after release; first FETCH on edge 3 with IRWE = PCWE = 1.
- R-type add (OPCODE 000000, FUNCT 100000) -> EXEC ALUsel = 0010, REGDST = 1; WB RFWE = 1 for one cycle; 4 cycles total. Repeat for sub 0110 and slt 0111.
- lw (100011) then sw (101011) -> lw: MEM then WB with MEMTOREG = 1, RFWE = 1, 5 cycles. sw: DMWE = 1 for one cycle in MEM, RFWE never 1, 4 cycles.
- beq (000100) with ZERO = 1, then with ZERO = 0 -> EXEC PCWE = 1, PCSRC = 01 when ZERO = 1; PCWE = 0 when ZERO = 0; 3 cycles each. j (000010) -> DECODE PCWE = 1, PCSRC = 10.
- OPCODE 111111, then R-type with FUNCT 000111 -> ILLEGAL one-cycle pulse in DECODE, RFWE = DMWE = 0, back to FETCH next cycle.
- CURST pulsed high during the MEM cycle of sw -> DMWE drops to 0 asynchronously, DMRST/RFRST/PCRRST = 1, state RSTSEQ, normal restart afterwards.

Source files
------------

// File: rtl/mips_control_sequencer.sv
// -----------------------------------------------------------------------------
// mips_control_sequencer
//
// Multi-cycle control unit for a simple MIPS datapath. After CURST it holds
// the datapath resets (DMRST/RFRST/PCRRST) for RST_CYCLES further edges, then
// runs FETCH -> DECODE -> EXEC -> MEM -> WB per instruction, skipping the
// states an instruction does not need.
//
// Ports
//   CLK       in   system clock, rising edge
//   CURST     in   asynchronous active-high reset of the sequencer
//   OPCODE    in   instr[31:26] from the instruction register
//   FUNCT     in   instr[5:0]
//   ZERO      in   ALU zero flag (used by beq in EXEC)
//   DMRST     out  data memory reset
//   RFRST     out  register file reset
//   PCRRST    out  PC register reset
//   IRWE      out  instruction register write enable
//   PCWE      out  PC write enable
//   PCSRC     out  00 PC+4, 01 branch target, 10 jump target
//   RFWE      out  register file write enable
//   REGDST    out  1 = rd, 0 = rt
//   ALUSRC    out  1 = sign-extended immediate, 0 = rt
//   MEMTOREG  out  1 = memory data, 0 = ALU result
//   DMWE      out  data memory write enable
//   ALUsel    out  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
//   ILLEGAL   out  one-cycle pulse in DECODE for an unsupported opcode/funct
// -----------------------------------------------------------------------------
module mips_control_sequencer #(
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       CURST,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       ZERO,
    output logic       DMRST,
    output logic       RFRST,
    output logic       PCRRST,
    output logic       IRWE,
    output logic       PCWE,
    output logic [1:0] PCSRC,
    output logic       RFWE,
    output logic       REGDST,
    output logic       ALUSRC,
    output logic       MEMTOREG,
    output logic       DMWE,
    output logic [3:0] ALUsel,
    output logic       ILLEGAL
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_RSTSEQ,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [5:0] r_op;

    logic       r_dmrst, r_rfrst, r_pcrrst;
    logic       r_irwe, r_pcwe, r_rfwe, r_dmwe;
    logic [1:0] r_pcsrc;
    logic       r_regdst, r_alusrc, r_memtoreg;
    logic [3:0] r_alusel;

    // ------------------------------------------------------------------
    // Instruction decode of the live IR fields. Only consumed in DECODE.
    // ------------------------------------------------------------------
    logic       w_funct_ok;
    logic [3:0] w_rfn_alu;
    logic       w_is_exec;
    logic       w_is_j;

    always_comb begin
        w_funct_ok = 1'b1;
        w_rfn_alu  = ALU_ADD;
        case (FUNCT)
            6'b100000: w_rfn_alu = ALU_ADD;
            6'b100010: w_rfn_alu = ALU_SUB;
            6'b100100: w_rfn_alu = ALU_AND;
            6'b100101: w_rfn_alu = ALU_OR;
            6'b101010: w_rfn_alu = ALU_SLT;
            default:   w_funct_ok = 1'b0;
        endcase
    end

    assign w_is_exec = ((OPCODE == OP_RTYPE) && w_funct_ok) ||
                       (OPCODE == OP_LW)   || (OPCODE == OP_SW) ||
                       (OPCODE == OP_ADDI) || (OPCODE == OP_BEQ);
    assign w_is_j    = (OPCODE == OP_J);

    // ------------------------------------------------------------------
    // State machine. Each branch assigns the outputs belonging to the
    // state being entered, so they are valid for that whole cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge CURST) begin
        if (CURST) begin
            r_state    <= S_RSTSEQ;
            r_cnt      <= 4'd0;
            r_op       <= 6'd0;
            r_dmrst    <= 1'b1;
            r_rfrst    <= 1'b1;
            r_pcrrst   <= 1'b1;
            r_irwe     <= 1'b0;
            r_pcwe     <= 1'b0;
            r_rfwe     <= 1'b0;
            r_dmwe     <= 1'b0;
            r_pcsrc    <= PC_SEQ;
            r_regdst   <= 1'b0;
            r_alusrc   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusel   <= ALU_ADD;
        end else begin
            // Defaults: quiet cycle; branches below override what they need.
            r_dmrst    <= 1'b0;
            r_rfrst    <= 1'b0;
            r_pcrrst   <= 1'b0;
            r_irwe     <= 1'b0;
            r_pcwe     <= 1'b0;
            r_rfwe     <= 1'b0;
            r_dmwe     <= 1'b0;
            r_pcsrc    <= PC_SEQ;
            r_regdst   <= 1'b0;
            r_alusrc   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusel   <= ALU_ADD;

            case (r_state)
                S_RSTSEQ: begin
                    if (r_cnt == 4'(RST_CYCLES)) begin
                        r_state <= S_FETCH;
                        r_irwe  <= 1'b1;
                        r_pcwe  <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 4'd1;
                        r_dmrst  <= 1'b1;
                        r_rfrst  <= 1'b1;
                        r_pcrrst <= 1'b1;
                    end
                end

                S_FETCH: begin
                    r_state <= S_DECODE;
                end

                S_DECODE: begin
                    r_op <= OPCODE;
                    if (w_is_exec) begin
                        r_state <= S_EXEC;
                        case (OPCODE)
                            OP_RTYPE: begin
                                r_regdst <= 1'b1;
                                r_alusel <= w_rfn_alu;
                            end
                            OP_BEQ: begin
                                r_alusel <= ALU_SUB;
                                r_pcsrc  <= PC_BRANCH;
                            end
                            default: r_alusrc <= 1'b1;   // lw / sw / addi
                        endcase
                    end else begin
                        // j and illegal both return straight to FETCH.
                        r_state <= S_FETCH;
                        r_irwe  <= 1'b1;
                        r_pcwe  <= 1'b1;
                    end
                end

                S_EXEC: begin
                    case (r_op)
                        OP_RTYPE: begin
                            r_state  <= S_WB;
                            r_rfwe   <= 1'b1;
                            r_regdst <= 1'b1;
                            r_alusel <= r_alusel;
                        end
                        OP_ADDI: begin
                            r_state  <= S_WB;
                            r_rfwe   <= 1'b1;
                            r_alusrc <= 1'b1;
                        end
                        OP_LW: begin
                            r_state  <= S_MEM;
                            r_alusrc <= 1'b1;
                        end
                        OP_SW: begin
                            r_state  <= S_MEM;
                            r_alusrc <= 1'b1;
                            r_dmwe   <= 1'b1;
                        end
                        default: begin           // beq
                            r_state <= S_FETCH;
                            r_irwe  <= 1'b1;
                            r_pcwe  <= 1'b1;
                        end
                    endcase
                end

                S_MEM: begin
                    if (r_op == OP_LW) begin
                        r_state    <= S_WB;
                        r_rfwe     <= 1'b1;
                        r_memtoreg <= 1'b1;
                        r_alusrc   <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                        r_irwe  <= 1'b1;
                        r_pcwe  <= 1'b1;
                    end
                end

                default: begin                   // S_WB and unused codes
                    r_state <= S_FETCH;
                    r_irwe  <= 1'b1;
                    r_pcwe  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // The IR is loaded on the edge that enters DECODE and ZERO only exists
    // during EXEC, so the jump/illegal strobes and the beq PC write are
    // qualified by the registered state and the live inputs of that cycle.
    // ------------------------------------------------------------------
    logic w_dec_j;
    logic w_beq_take;

    assign w_dec_j    = (r_state == S_DECODE) && w_is_j;
    assign w_beq_take = (r_state == S_EXEC) && (r_op == OP_BEQ) && ZERO;

    assign DMRST    = r_dmrst;
    assign RFRST    = r_rfrst;
    assign PCRRST   = r_pcrrst;
    assign IRWE     = r_irwe;
    assign PCWE     = r_pcwe | w_dec_j | w_beq_take;
    assign PCSRC    = w_dec_j ? PC_JUMP : r_pcsrc;
    assign RFWE     = r_rfwe;
    assign REGDST   = r_regdst;
    assign ALUSRC   = r_alusrc;
    assign MEMTOREG = r_memtoreg;
    assign DMWE     = r_dmwe;
    assign ALUsel   = r_alusel;
    assign ILLEGAL  = (r_state == S_DECODE) && !w_is_exec && !w_is_j;

endmodule

// File: tb/tb_mips_control_sequencer.sv
module tb_mips_control_sequencer;

    localparam int RST_CYCLES = 2;

    logic       CLK = 1'b0;
    logic       CURST;
    logic [5:0] OPCODE, FUNCT;
    logic       ZERO;
    logic       DMRST, RFRST, PCRRST, IRWE, PCWE, RFWE, REGDST, ALUSRC, MEMTOREG, DMWE, ILLEGAL;
    logic [1:0] PCSRC;
    logic [3:0] ALUsel;

    mips_control_sequencer #(.RST_CYCLES(RST_CYCLES)) dut (
        .CLK(CLK), .CURST(CURST), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO),
        .DMRST(DMRST), .RFRST(RFRST), .PCRRST(PCRRST), .IRWE(IRWE), .PCWE(PCWE),
        .PCSRC(PCSRC), .RFWE(RFWE), .REGDST(REGDST), .ALUSRC(ALUSRC),
        .MEMTOREG(MEMTOREG), .DMWE(DMWE), .ALUsel(ALUsel), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       dmrst, rfrst, pcrrst, irwe, pcwe;
        logic [1:0] pcsrc;
        logic       rfwe, regdst, alusrc, memtoreg, dmwe;
        logic [3:0] alusel;
        logic       illegal;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (mon_en) begin
            rec_t act, e;
            act = '{DMRST, RFRST, PCRRST, IRWE, PCWE, PCSRC, RFWE, REGDST,
                    ALUSRC, MEMTOREG, DMWE, ALUsel, ILLEGAL};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL underflow t=%0t act=%h required=<none>", $time, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t act=%h required=%h", $time, act, e);
                end
            end
        end
    end

    function automatic rec_t rst_rec();
        rec_t r = '0;
        r.dmrst = 1; r.rfrst = 1; r.pcrrst = 1; r.alusel = 4'b0010;
        return r;
    endfunction

    function automatic bit rfn_alu(input logic [5:0] fn, output logic [3:0] alu);
        alu = 4'b0010;
        case (fn)
            6'b100000: alu = 4'b0010;
            6'b100010: alu = 4'b0110;
            6'b100100: alu = 4'b0000;
            6'b100101: alu = 4'b0001;
            6'b101010: alu = 4'b0111;
            default:   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic step(input rec_t e);
        exp_q.push_back(e);
        @(posedge CLK); #1;
    endtask

    task automatic reset_seq(input int hold);
        CURST = 1'b1;
        for (int i = 0; i < hold; i++) step(rst_rec());
        CURST = 1'b0;
        for (int i = 0; i <= RST_CYCLES; i++) step(rst_rec());
    endtask

    // Reference: per-instruction list of per-cycle control words, built from
    // the instruction class. OPCODE/FUNCT are only meaningful in DECODE and
    // ZERO only in EXEC; every other cycle gets random values.
    task automatic build_seq(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, output rec_t seq[$]);
        rec_t f, idle, r;
        logic [3:0] a;
        seq = {};
        f = '0; f.irwe = 1; f.pcwe = 1; f.alusel = 4'b0010;
        idle = '0; idle.alusel = 4'b0010;
        seq.push_back(f);
        if (op == 6'b000000 && rfn_alu(fn, a)) begin
            seq.push_back(idle);
            r = idle; r.regdst = 1; r.alusel = a; seq.push_back(r);
            r.rfwe = 1; seq.push_back(r);
        end else if (op == 6'b001000) begin
            seq.push_back(idle);
            r = idle; r.alusrc = 1; seq.push_back(r);
            r.rfwe = 1; seq.push_back(r);
        end else if (op == 6'b100011) begin
            seq.push_back(idle);
            r = idle; r.alusrc = 1; seq.push_back(r); seq.push_back(r);
            r.rfwe = 1; r.memtoreg = 1; seq.push_back(r);
        end else if (op == 6'b101011) begin
            seq.push_back(idle);
            r = idle; r.alusrc = 1; seq.push_back(r);
            r.dmwe = 1; seq.push_back(r);
        end else if (op == 6'b000100) begin
            seq.push_back(idle);
            r = idle; r.alusel = 4'b0110; r.pcsrc = 2'b01; r.pcwe = z; seq.push_back(r);
        end else if (op == 6'b000010) begin
            r = idle; r.pcwe = 1; r.pcsrc = 2'b10; seq.push_back(r);
        end else begin
            r = idle; r.illegal = 1; seq.push_back(r);
        end
    endtask

    task automatic drive(input int i, input logic [5:0] op, input logic [5:0] fn, input logic z);
        OPCODE = (i == 1) ? op : 6'($urandom);
        FUNCT  = (i == 1) ? fn : 6'($urandom);
        ZERO   = (i == 2) ? z  : 1'($urandom);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        rec_t seq[$];
        build_seq(op, fn, z, seq);
        for (int i = 0; i < seq.size(); i++) begin
            drive(i, op, fn, z);
            step(seq[i]);
        end
    endtask

    task automatic run_random();
        logic [5:0] ops[9];
        logic [5:0] fns[6];
        logic [5:0] op, fn;
        ops = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b001000,
                6'b000100, 6'b000010, 6'b000000, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        op = ops[$urandom_range(0, 8)];
        if ($urandom_range(0, 9) == 0) op = 6'($urandom);
        fn = fns[$urandom_range(0, 5)];
        if (fn == 6'b000000) fn = 6'($urandom);
        run_instr(op, fn, 1'($urandom));
    endtask

    // sw aborted by CURST in the middle of its MEM cycle.
    task automatic sw_abort();
        rec_t seq[$];
        build_seq(6'b101011, 6'd0, 1'b0, seq);
        for (int i = 0; i < 3; i++) begin
            drive(i, 6'b101011, 6'd0, 1'b0);
            step(seq[i]);
        end
        checks++;
        if (DMWE !== 1'b1) begin
            errors++;
            $display("FAIL sw_mem_dmwe act=%b required=1", DMWE);
        end
        #2 CURST = 1'b1;
        #1;
        checks++;
        if ({DMWE, RFWE, DMRST, RFRST, PCRRST} !== 5'b00111) begin
            errors++;
            $display("FAIL async_abort act=%b required=00111", {DMWE, RFWE, DMRST, RFRST, PCRRST});
        end
        step(rst_rec());
        reset_seq(1);
    endtask

    initial begin
        CURST = 1'b1; OPCODE = '0; FUNCT = '0; ZERO = 1'b0;
        @(posedge CLK); #1;
        mon_en = 1;
        reset_seq(3);

        run_instr(6'b000000, 6'b100000, 1'b0);   // add
        run_instr(6'b000000, 6'b100010, 1'b0);   // sub
        run_instr(6'b000000, 6'b101010, 1'b0);   // slt
        run_instr(6'b000000, 6'b100100, 1'b0);   // and
        run_instr(6'b000000, 6'b100101, 1'b0);   // or
        run_instr(6'b100011, 6'd0, 1'b0);        // lw
        run_instr(6'b101011, 6'd0, 1'b0);        // sw
        run_instr(6'b001000, 6'd0, 1'b0);        // addi
        run_instr(6'b000100, 6'd0, 1'b1);        // beq taken
        run_instr(6'b000100, 6'd0, 1'b0);        // beq not taken
        run_instr(6'b000010, 6'd0, 1'b0);        // j
        run_instr(6'b111111, 6'd0, 1'b0);        // illegal opcode
        run_instr(6'b000000, 6'b000111, 1'b0);   // illegal funct

        for (int n = 0; n < 80; n++) run_random();
        sw_abort();
        for (int n = 0; n < 20; n++) run_random();

        mon_en = 0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover act=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
